// File: rtl/cordic_req_arbiter.sv
// ============================================================================
// Module      : cordic_req_arbiter
// Description : Round-robin front end that serialises NREQ requesters onto a
//               single CORDIC engine and returns one response per request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*8-1:0]    req_mode,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic                 eng_call,
    output logic [7:0]           eng_mode,
    output logic [31:0]          eng_data,
    output logic [31:0]          eng_data2,
    input  logic                 eng_done,
    input  logic [31:0]          eng_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              eng_call_q;
    logic [7:0]        eng_mode_q;
    logic [31:0]       eng_data_q, eng_data2_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [31:0]       rsp_data_q;
    logic              rsp_err_q;

    logic [7:0]        mode_arr [NREQ];
    logic [31:0]       a_arr    [NREQ];
    logic [31:0]       b_arr    [NREQ];
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              accept;
    logic              mode_ok;
    logic              timeout_hit;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign mode_arr[gi] = req_mode[8*gi +: 8];
        assign a_arr[gi]    = req_a[32*gi +: 32];
        assign b_arr[gi]    = req_b[32*gi +: 32];
    end

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        return ID_W'((int'(base) + off) % NREQ);
    endfunction

    // Search starts one past the last grant, so the previous winner is checked last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!grant_found && req_valid[wrap_idx(last_grant_q, i)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(last_grant_q, i);
            end
        end
    end

    assign accept      = (state_q == IDLE) && grant_found;
    assign mode_ok     = (mode_arr[grant_idx] != 8'd0) && (mode_arr[grant_idx] <= 8'd11);
    assign timeout_hit = (cnt_q == c_cnt_last);
    assign req_ready   = accept ? (NREQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = mode_ok ? RUN : RESP;
                end
            end
            RUN: begin
                if (eng_done || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NREQ - 1);
            cnt_q        <= '0;
            eng_call_q   <= 1'b0;
            eng_mode_q   <= 8'd0;
            eng_data_q   <= 32'd0;
            eng_data2_q  <= 32'd0;
            rsp_id_q     <= '0;
            rsp_data_q   <= 32'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            eng_call_q <= (state_d == RUN);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        last_grant_q <= grant_idx;
                        rsp_id_q     <= grant_idx;
                        eng_mode_q   <= mode_arr[grant_idx];
                        eng_data_q   <= a_arr[grant_idx];
                        eng_data2_q  <= b_arr[grant_idx];
                        cnt_q        <= '0;
                        if (!mode_ok) begin
                            rsp_err_q  <= 1'b1;
                            rsp_data_q <= 32'd0;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A completion in the timeout cycle still delivers its result.
                    if (eng_done) begin
                        rsp_data_q <= eng_result;
                        rsp_err_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data_q <= 32'd0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_call  = eng_call_q;
    assign eng_mode  = eng_mode_q;
    assign eng_data  = eng_data_q;
    assign eng_data2 = eng_data2_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_cordic_req_arbiter.sv
// ============================================================================
// Module      : tb_cordic_req_arbiter
// Description : Scoreboard bench for cordic_req_arbiter with a behavioural engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_req_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [31:0]  req_mode;
    logic [127:0] req_a, req_b;
    logic         eng_call;
    logic [7:0]   eng_mode;
    logic [31:0]  eng_data, eng_data2;
    logic         eng_done;
    logic [31:0]  eng_result;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic         rsp_err;

    cordic_req_arbiter #(.NREQ(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_a(req_a), .req_b(req_b),
        .eng_call(eng_call), .eng_mode(eng_mode), .eng_data(eng_data), .eng_data2(eng_data2),
        .eng_done(eng_done), .eng_result(eng_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int          n_rsp    = 0;
    int          eng_lat  = 0;
    bit          use_model = 1'b0;
    logic [31:0] eng_val  = 32'd0;

    function automatic logic [31:0] f_model(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b);
        return ({m, 24'h0} ^ a ^ {b[15:0], b[31:16]}) + 32'h0000_1357;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [31:0] d, input logic e);
        rsp_t r;
        r.id = id; r.data = d; r.err = e;
        exp_q.push_back(r);
    endtask

    task automatic set_req(input int id, input logic [7:0] m, input logic [31:0] a, input logic [31:0] b);
        req_mode[id*8 +: 8]  = m;
        req_a[id*32 +: 32]   = a;
        req_b[id*32 +: 32]   = b;
        req_valid[id]        = 1'b1;
    endtask

    // Present one request alone, confirm the strobe, return one cycle after accept.
    task automatic single_req(input int id, input logic [7:0] m, input logic [31:0] a, input logic [31:0] b);
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0001 << id;
        set_req(id, m, a, b);
        @(negedge clk);
        chk("req_ready_onehot", {28'd0, req_ready}, {28'd0, exp_rdy});
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc, output logic call1, output logic call_seen,
                            output logic [31:0] d1, output logic [31:0] d2);
        cyc = 0; call1 = 1'b0; call_seen = 1'b0; d1 = '0; d2 = '0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                call1 = eng_call; d1 = eng_data; d2 = eng_data2;
            end
            if (eng_call) call_seen = 1'b1;
            if (rsp_valid) return;
        end
        checks++; failures++;
        $display("FAIL rsp_wait: got no rsp_valid within 200 cycles required one");
    endtask

    // Behavioural engine: completes eng_lat cycles after eng_call rises (0 = never).
    initial begin
        int lat;
        eng_done = 1'b0; eng_result = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (eng_call) begin
                lat = eng_lat;
                if (lat > 0) begin
                    repeat (lat - 1) @(posedge clk);
                    #1;
                    eng_done   = 1'b1;
                    eng_result = use_model ? f_model(eng_mode, eng_data, eng_data2) : eng_val;
                    @(posedge clk); #1;
                    eng_done   = 1'b0;
                end
                while (eng_call) begin
                    @(posedge clk); #1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_rsp: got id=%0d data=0x%08h err=%0b required none", rsp_id, rsp_data, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_id",   {30'd0, rsp_id},  {30'd0, mon_e.id});
                chk("rsp_data", rsp_data,         mon_e.data);
                chk("rsp_err",  {31'd0, rsp_err}, {31'd0, mon_e.err});
            end
            n_rsp++;
        end
    end

    initial begin
        int          cyc;
        logic        call1, call_seen;
        logic [31:0] d1, d2;

        reset = 1'b1; req_valid = '0; req_mode = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_eng_call",  {31'd0, eng_call},  32'd0);
        chk("rst_eng_mode",  {24'd0, eng_mode},  32'd0);
        chk("rst_eng_data",  eng_data,           32'd0);
        chk("rst_eng_data2", eng_data2,          32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_id",    {30'd0, rsp_id},    32'd0);
        chk("rst_rsp_data",  rsp_data,           32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Fairness: all four held, expect grants 0,1,2,3,0.
        use_model = 1'b1; eng_lat = 2;
        for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 32'h100 * (i + 1), 32'h11 * i);
        for (int i = 0; i < 5; i++) push_exp(2'(i % 4), f_model(8'((i % 4) + 1), 32'h100 * ((i % 4) + 1), 32'h11 * (i % 4)), 1'b0);
        for (int n = 0; n < 200 && n_rsp < 5; n++) begin
            @(posedge clk); #1;
        end
        req_valid = '0;
        chk("fair_count", n_rsp, 5);

        // Single request with hand-computed latency.
        use_model = 1'b0; eng_val = 32'h1234_5678; eng_lat = 5;
        push_exp(2'd0, 32'h1234_5678, 1'b0);
        single_req(0, 8'd1, 32'h0000_4000, 32'd0);
        wait_rsp(cyc, call1, call_seen, d1, d2);
        chk("single_latency", cyc, 6);
        chk("single_call",    {31'd0, call1}, 32'd1);
        chk("single_data",    d1, 32'h0000_4000);
        @(posedge clk); #1;

        // Invalid modes: 0x0C on requester 2, 0 on requester 1.
        push_exp(2'd2, 32'd0, 1'b1);
        single_req(2, 8'h0C, 32'hDEAD_BEEF, 32'd1);
        wait_rsp(cyc, call1, call_seen, d1, d2);
        chk("inv12_latency", cyc, 1);
        chk("inv12_nocall",  {31'd0, call_seen}, 32'd0);
        @(posedge clk); #1;
        push_exp(2'd1, 32'd0, 1'b1);
        single_req(1, 8'h00, 32'h1, 32'h2);
        wait_rsp(cyc, call1, call_seen, d1, d2);
        chk("inv0_latency", cyc, 1);
        chk("inv0_nocall",  {31'd0, call_seen}, 32'd0);
        @(posedge clk); #1;

        // Timeout: engine never completes.
        eng_lat = 0;
        push_exp(2'd3, 32'd0, 1'b1);
        single_req(3, 8'd7, 32'h3, 32'h4);
        wait_rsp(cyc, call1, call_seen, d1, d2);
        chk("tmo_latency", cyc, 65);
        chk("tmo_call_run", {31'd0, call1}, 32'd1);
        chk("tmo_call_off", {31'd0, eng_call}, 32'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("tmo_call_stays_off", {31'd0, eng_call}, 32'd0);
        end
        @(posedge clk); #1;

        // Backpressure with arctan operands; a competing request must wait.
        rsp_ready = 1'b0; use_model = 1'b1; eng_lat = 3;
        push_exp(2'd1, f_model(8'd8, 32'h100, 32'h200), 1'b0);
        single_req(1, 8'd8, 32'h100, 32'h200);
        wait_rsp(cyc, call1, call_seen, d1, d2);
        chk("bp_latency", cyc, 4);
        chk("bp_eng_data",  d1, 32'h100);
        chk("bp_eng_data2", d2, 32'h200);
        chk("bp_eng_mode",  {24'd0, eng_mode}, 32'd8);
        set_req(0, 8'd2, 32'h55, 32'd0);
        push_exp(2'd0, f_model(8'd2, 32'h55, 32'd0), 1'b0);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_data",  rsp_data, f_model(8'd8, 32'h100, 32'h200));
            chk("bp_no_accept", {28'd0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_next_grant", {28'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_rsp(cyc, call1, call_seen, d1, d2);
        chk("bp_next_latency", cyc, 4);
        @(posedge clk); #1;

        // Reset two cycles after accept aborts silently and restores priority.
        eng_lat = 20;
        single_req(2, 8'd3, 32'h77, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstrun_call",  {31'd0, eng_call},  32'd0);
        chk("rstrun_valid", {31'd0, rsp_valid}, 32'd0);
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            chk("rstrun_quiet", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        eng_lat = 2;
        set_req(3, 8'd4, 32'h33, 32'h44);
        set_req(0, 8'd5, 32'h66, 32'h88);
        push_exp(2'd0, f_model(8'd5, 32'h66, 32'h88), 1'b0);
        push_exp(2'd3, f_model(8'd4, 32'h33, 32'h44), 1'b0);
        @(negedge clk);
        chk("rstrun_grant0", {28'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        for (int n = 0; n < 100 && req_ready[3] !== 1'b1; n++) @(negedge clk);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;

        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
